ddr_write_burst_ctrl: RTL and testbench

Single-clock controller that drains a ping-pong line buffer into DDR over AXI4 write bursts. It sits on the DDR-side (read) clock of the dual-port write buffer RAM. It counts banks reported full by the capture side, drives the buffer read address, streams buffer words onto the AXI W channel and completes each burst through the B channel. Each bank is exactly one AXI burst, and burst addresses advance linearly from a per-frame DDR base.

---
 rtl/ddr_write_burst_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ddr_write_burst_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_write_burst_ctrl.sv
// Drains a ping-pong line buffer into DDR as one AXI4 write burst per bank.
// Latency: bank_full_i -> awvalid_o in 2 cycles; L-beat burst period is L+4 cycles.
// Backpressure: AW/W/B stalls hold valids, address and read address stable; W beats gated by wready_i.
//
// Ports:
//   clk_i, resetn_i            DDR-side clock (also buffer read clock), sync active-low reset
//   frame_start_i, ddr_base_i  new frame base; applied now in IDLE, else deferred to the next IDLE
//   bank_full_i                one bank of the buffer has been written (already synchronised)
//   rd_addr_o, rd_data_i       buffer read port; data arrives one cycle after the address
//   aw*/w*/b*                  AXI4 write address, data and response channels
//   busy_o                     controller not idle
//   overflow_o, err_o          sticky: bank_full_i with two banks pending / non-OKAY bresp_i
module ddr_write_burst_ctrl #(
  parameter int g_BUFF_AWIDTH = 8,
  parameter int g_DWIDTH      = 64,
  parameter int g_AXI_AWIDTH  = 32
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     frame_start_i,
  input  logic [g_AXI_AWIDTH-1:0]  ddr_base_i,
  input  logic                     bank_full_i,
  output logic [g_BUFF_AWIDTH-1:0] rd_addr_o,
  input  logic [g_DWIDTH-1:0]      rd_data_i,
  output logic [g_AXI_AWIDTH-1:0]  awaddr_o,
  output logic [7:0]               awlen_o,
  output logic                     awvalid_o,
  input  logic                     awready_i,
  output logic [g_DWIDTH-1:0]      wdata_o,
  output logic                     wlast_o,
  output logic                     wvalid_o,
  input  logic                     wready_i,
  input  logic [1:0]               bresp_i,
  input  logic                     bvalid_i,
  output logic                     bready_o,
  output logic                     busy_o,
  output logic                     overflow_o,
  output logic                     err_o
);

  localparam int BW = g_BUFF_AWIDTH - 1;
  localparam logic [BW-1:0] BEAT_MAX = '1;
  localparam logic [7:0] AWLEN = 8'((2 ** BW) - 1);
  localparam logic [g_AXI_AWIDTH-1:0] BURST_BYTES = g_AXI_AWIDTH'((2 ** BW) * (g_DWIDTH / 8));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_PREF, S_W, S_B} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              pending_q, pending_d;
  logic                    bank_q, bank_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [g_AXI_AWIDTH-1:0] offset_q, offset_d;
  logic [g_AXI_AWIDTH-1:0] base_q, base_d;
  logic [g_AXI_AWIDTH-1:0] awaddr_q, awaddr_d;
  logic [g_AXI_AWIDTH-1:0] fs_base_q, fs_base_d;
  logic                    fs_pend_q, fs_pend_d;
  logic                    overflow_q, overflow_d;
  logic                    err_q, err_d;
  logic                    w_hs;
  logic                    b_hs;

  assign awlen_o    = AWLEN;
  assign awaddr_o   = awaddr_q;
  assign wdata_o    = rd_data_i;
  assign overflow_o = overflow_q;
  assign err_o      = err_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    bank_d     = bank_q;
    beat_d     = beat_q;
    offset_d   = offset_q;
    base_d     = base_q;
    awaddr_d   = awaddr_q;
    fs_base_d  = fs_base_q;
    fs_pend_d  = fs_pend_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    awvalid_o  = 1'b0;
    wvalid_o   = 1'b0;
    wlast_o    = 1'b0;
    bready_o   = 1'b0;
    rd_addr_o  = '0;
    busy_o     = (state_q != S_IDLE);

    w_hs = (state_q == S_W) && wready_i;
    b_hs = (state_q == S_B) && bvalid_i;

    // A fill and a drain in the same cycle cancel; only a net fill can overflow.
    if (bank_full_i && !b_hs) begin
      if (pending_q == 2'd2) overflow_d = 1'b1;
      else                   pending_d  = pending_q + 2'd1;
    end else if (!bank_full_i && b_hs) begin
      pending_d = pending_q - 2'd1;
    end

    // Outside IDLE the new base is parked so the burst in flight keeps its address.
    if (frame_start_i) begin
      if (state_q == S_IDLE) begin
        base_d    = ddr_base_i;
        offset_d  = '0;
        fs_pend_d = 1'b0;
      end else begin
        fs_base_d = ddr_base_i;
        fs_pend_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q != 2'd0) begin
          state_d  = S_AW;
          // Next-state base/offset so a same-cycle frame start is honoured.
          awaddr_d = base_d + offset_d;
        end
      end
      S_AW: begin
        awvalid_o = 1'b1;
        if (awready_i) state_d = S_PREF;
      end
      S_PREF: begin
        // Prime the registered RAM read so beat 0 is on rd_data_i in the first W cycle.
        rd_addr_o = {bank_q, {BW{1'b0}}};
        beat_d    = '0;
        state_d   = S_W;
      end
      S_W: begin
        wvalid_o  = 1'b1;
        wlast_o   = (beat_q == BEAT_MAX);
        // Look one word ahead on a handshake; hold the address during a stall.
        rd_addr_o = {bank_q, beat_q + BW'(w_hs)};
        if (w_hs) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_MAX) state_d = S_B;
        end
      end
      S_B: begin
        bready_o = 1'b1;
        if (b_hs) begin
          if (bresp_i != 2'b00) err_d = 1'b1;
          bank_d  = ~bank_q;
          state_d = S_IDLE;
          if (fs_pend_d) begin
            base_d    = fs_base_d;
            offset_d  = '0;
            fs_pend_d = 1'b0;
          end else begin
            offset_d = offset_q + BURST_BYTES;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      pending_q  <= 2'd0;
      bank_q     <= 1'b0;
      beat_q     <= '0;
      offset_q   <= '0;
      base_q     <= '0;
      awaddr_q   <= '0;
      fs_base_q  <= '0;
      fs_pend_q  <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      bank_q     <= bank_d;
      beat_q     <= beat_d;
      offset_q   <= offset_d;
      base_q     <= base_d;
      awaddr_q   <= awaddr_d;
      fs_base_q  <= fs_base_d;
      fs_pend_q  <= fs_pend_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr_write_burst_ctrl.sv
// Directed bench for ddr_write_burst_ctrl with a registered-read buffer RAM model.
// Bursts of 128 beats (g_BUFF_AWIDTH=8), 64-bit data, 32-bit AXI addresses.
// Slave readies are driven per cycle, optionally randomised to create stalls.
module tb_ddr_write_burst_ctrl;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        frame_start_i;
  logic [31:0] ddr_base_i;
  logic        bank_full_i;
  logic [7:0]  rd_addr_o;
  logic [63:0] rd_data_i;
  logic [31:0] awaddr_o;
  logic [7:0]  awlen_o;
  logic        awvalid_o;
  logic        awready_i;
  logic [63:0] wdata_o;
  logic        wlast_o;
  logic        wvalid_o;
  logic        wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i;
  logic        bready_o;
  logic        busy_o;
  logic        overflow_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int aw_wait;

  logic [63:0] mem [256];

  always #5 clk_i = ~clk_i;

  // Buffer RAM: registered read, data follows the address by one cycle.
  always @(posedge clk_i) rd_data_i <= mem[rd_addr_o];

  ddr_write_burst_ctrl #(
    .g_BUFF_AWIDTH(8),
    .g_DWIDTH(64),
    .g_AXI_AWIDTH(32)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .frame_start_i(frame_start_i), .ddr_base_i(ddr_base_i),
    .bank_full_i(bank_full_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .busy_o(busy_o), .overflow_o(overflow_o), .err_o(err_o)
  );

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h0BAD_F00D ^ 32'(i)};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_full();
    bank_full_i = 1'b1;
    step();
    bank_full_i = 1'b0;
  endtask

  task automatic pulse_frame(input logic [31:0] base);
    frame_start_i = 1'b1;
    ddr_base_i    = base;
    step();
    frame_start_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({awvalid_o, wvalid_o, wlast_o, bready_o, busy_o, overflow_o, err_o} !== 7'b0) begin
      errors++;
      $display("FAIL %s flags: got aw=%b w=%b last=%b b=%b busy=%b ovf=%b err=%b, required all 0",
               tag, awvalid_o, wvalid_o, wlast_o, bready_o, busy_o, overflow_o, err_o);
    end
    checks++;
    if (awaddr_o !== 32'h0) begin
      errors++; $display("FAIL %s awaddr: got %h required 00000000", tag, awaddr_o);
    end
    checks++;
    if (rd_addr_o !== 8'h0) begin
      errors++; $display("FAIL %s rd_addr: got %h required 00", tag, rd_addr_o);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++; $display("FAIL %s: got %b required %b", tag, got, req);
    end
  endtask

  // Plays the AXI slave for one burst and checks address, data, wlast and stall stability.
  task automatic do_burst(input logic [31:0] exp_addr, input int bnk, input bit stall,
                          input logic [1:0] resp, input bit coinc, input bit fs,
                          input int abort_beat, output int aw_w);
    int beat;
    int cyc;
    bit prev_stall;
    bit fs_done;
    aw_w = 0;
    prev_stall = 0;
    forever begin
      step();
      awready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (awvalid_o) begin
        checks++;
        if (awaddr_o !== exp_addr) begin
          errors++; $display("FAIL awaddr: got %h required %h", awaddr_o, exp_addr);
        end
        if (awready_i) break;
        prev_stall = 1;
      end else begin
        if (prev_stall) begin
          checks++; errors++;
          $display("FAIL awvalid_drop: got 0 required 1 after stall");
        end
        aw_w++;
        if (aw_w > 100) begin
          checks++; errors++;
          $display("FAIL aw_timeout: got no awvalid required awvalid within 100 cycles");
          awready_i = 1'b0;
          return;
        end
      end
    end

    beat = 0; cyc = 0; fs_done = 0;
    while (beat < 128) begin
      step();
      awready_i = 1'b0;
      wready_i  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      frame_start_i = 1'b0;
      if (fs && !fs_done && beat == 5) begin
        frame_start_i = 1'b1;
        ddr_base_i    = 32'h2000_0000;
        fs_done       = 1;
      end
      #1;
      cyc++;
      if (wvalid_o) begin
        checks++;
        if (wdata_o !== pat(bnk * 128 + beat)) begin
          errors++; $display("FAIL wdata beat %0d: got %h required %h", beat, wdata_o, pat(bnk * 128 + beat));
        end
        checks++;
        if (wlast_o !== 1'(beat == 127)) begin
          errors++; $display("FAIL wlast beat %0d: got %b required %b", beat, wlast_o, beat == 127);
        end
        if (!wready_i) begin
          checks++;
          if (rd_addr_o !== 8'(bnk * 128 + beat)) begin
            errors++; $display("FAIL rd_addr_stall: got %h required %h", rd_addr_o, 8'(bnk * 128 + beat));
          end
        end else begin
          beat++;
        end
      end else if (beat > 0) begin
        checks++; errors++;
        $display("FAIL wvalid_drop beat %0d: got 0 required 1", beat);
      end
      if (abort_beat >= 0 && beat >= abort_beat) begin
        frame_start_i = 1'b0;
        return;
      end
      if (cyc > 2000) begin
        checks++; errors++;
        $display("FAIL w_timeout: got %0d beats required 128", beat);
        wready_i = 1'b0;
        return;
      end
    end
    if (!stall) begin
      checks++;
      if (cyc !== 129) begin
        errors++; $display("FAIL w_cycles: got %0d required 129 (PREF + 128 beats)", cyc);
      end
    end

    cyc = 0;
    forever begin
      step();
      wready_i      = 1'b0;
      frame_start_i = 1'b0;
      bvalid_i      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bresp_i       = resp;
      bank_full_i   = coinc && bvalid_i;
      #1;
      if (bvalid_i && bready_o) break;
      cyc++;
      if (cyc > 100) begin
        checks++; errors++;
        $display("FAIL b_timeout: got bready=%b required 1", bready_o);
        bvalid_i = 1'b0; bank_full_i = 1'b0;
        return;
      end
    end
    step();
    bvalid_i    = 1'b0;
    bresp_i     = 2'b00;
    bank_full_i = 1'b0;
  endtask

  task automatic apply_reset();
    resetn_i = 1'b0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    bank_full_i = 1'b0; frame_start_i = 1'b0;
    step();
    step();
    resetn_i = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    check_all_zero("reset");
    checks++;
    if (awlen_o !== 8'd127) begin
      errors++; $display("FAIL awlen: got %0d required 127", awlen_o);
    end
  endtask

  task automatic test_single();
    pulse_frame(32'h1000_0000);
    pulse_full();
    check_bit("single_awvalid_n1", awvalid_o, 1'b0);
    do_burst(32'h1000_0000, 0, 0, 2'b00, 0, 0, -1, aw_wait);
    checks++;
    if (aw_wait !== 0) begin
      errors++; $display("FAIL single_aw_latency: got %0d extra cycles required 0", aw_wait);
    end
    check_bit("single_busy_after", busy_o, 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pulse_frame(32'h1000_0000);
    bank_full_i = 1'b1;
    step();
    step();
    bank_full_i = 1'b0;
    do_burst(32'h1000_0000, 0, 0, 2'b00, 0, 0, -1, aw_wait);
    check_bit("b2b_busy_between", busy_o, 1'b0);
    do_burst(32'h1000_0400, 1, 0, 2'b00, 0, 0, -1, aw_wait);
    checks++;
    if (aw_wait !== 0) begin
      errors++; $display("FAIL b2b_period: got %0d extra cycles required 0", aw_wait);
    end
    check_bit("b2b_busy_after", busy_o, 1'b0);
  endtask

  task automatic test_stalls();
    pulse_full();
    do_burst(32'h1000_0800, 0, 1, 2'b00, 0, 0, -1, aw_wait);
    check_bit("stall_busy_after", busy_o, 1'b0);
    check_bit("stall_err", err_o, 1'b0);
  endtask

  task automatic test_overflow();
    bank_full_i = 1'b1;
    step();
    step();
    step();
    bank_full_i = 1'b0;
    check_bit("overflow_set", overflow_o, 1'b1);
    do_burst(32'h1000_0C00, 1, 0, 2'b00, 0, 0, -1, aw_wait);
    do_burst(32'h1000_1000, 0, 0, 2'b00, 0, 0, -1, aw_wait);
    check_bit("overflow_sticky", overflow_o, 1'b1);
    check_bit("overflow_drained", busy_o, 1'b0);
    // Fill coincident with the B handshake leaves one bank still pending.
    pulse_full();
    do_burst(32'h1000_1400, 1, 0, 2'b00, 1, 0, -1, aw_wait);
    do_burst(32'h1000_1800, 0, 0, 2'b00, 0, 0, -1, aw_wait);
    checks++;
    if (aw_wait !== 0) begin
      errors++; $display("FAIL coinc_next_burst: got %0d extra cycles required 0", aw_wait);
    end
    repeat (5) step();
    check_bit("coinc_idle", busy_o, 1'b0);
  endtask

  task automatic test_frame_start();
    pulse_full();
    do_burst(32'h1000_1C00, 1, 0, 2'b10, 0, 1, -1, aw_wait);
    check_bit("err_set", err_o, 1'b1);
    pulse_full();
    do_burst(32'h2000_0000, 0, 0, 2'b00, 0, 0, -1, aw_wait);
    check_bit("err_sticky", err_o, 1'b1);
  endtask

  task automatic test_reset_mid();
    pulse_full();
    do_burst(32'h2000_0400, 1, 0, 2'b00, 0, 0, 20, aw_wait);
    check_bit("mid_busy_before", busy_o, 1'b1);
    resetn_i = 1'b0;
    wready_i = 1'b0;
    step();
    check_all_zero("reset_mid");
    resetn_i = 1'b1;
    step();
    check_bit("reset_mid_stays_idle", busy_o, 1'b0);
    pulse_full();
    do_burst(32'h0000_0000, 0, 0, 2'b00, 0, 0, -1, aw_wait);
    check_bit("reset_mid_busy_after", busy_o, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    resetn_i = 1'b0; frame_start_i = 1'b0; ddr_base_i = '0; bank_full_i = 1'b0;
    awready_i = 1'b0; wready_i = 1'b0; bresp_i = 2'b00; bvalid_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stalls();
    test_overflow();
    test_frame_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
